uart_loader: RTL

Boot-time program loader that sits behind the UART receiver and sequences its byte stream into instruction-memory writes. The host sends a 32-bit little-endian word count N, then N 32-bit little-endian words. The loader packs the bytes, writes word k to memory address k, and reports completion or a classified error. The CPU core is held off by `busy` until `done`.

---
 rtl/uart_loader_pkg.sv | 21 ++
 rtl/uart_byte_packer.sv | 35 +++
 rtl/uart_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types for the UART boot loader: FSM states, error codes and packer index width.
package uart_loader_pkg;

  localparam int BYTE_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_FRAME   = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

endpackage

// File: rtl/uart_byte_packer.sv
// Little-endian 8->32 packer. The completed word and its strobe are presented in the
// same cycle as the 4th byte so the loader can register the memory write one cycle later.
module uart_byte_packer
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BYTE_IDX_W-1:0] idx;
  logic [23:0]           shreg;

  // Only the three earlier bytes need storage; the 4th is taken straight from the input.
  assign word       = {byte_data, shreg};
  assign word_valid = byte_valid && (idx == BYTE_IDX_W'(3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= '0;
      shreg <= '0;
    end else if (byte_valid) begin
      idx   <= idx + BYTE_IDX_W'(1);
      shreg <= {byte_data, shreg[23:8]};
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Boot loader FSM: reads a 32-bit word count N, then writes N packed words to
// instruction memory starting at address 0, reporting done or a classified error.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int          ADDR_W      = 15,
  parameter int unsigned MAX_WORDS   = 2**ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int          TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [31:0] MAX_N    = 32'(MAX_WORDS);

  loader_state_t    state;
  logic [ADDR_W:0]  len_reg;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_armed;
  logic             receiving;
  logic             rearm;
  logic             byte_acc;
  logic             tmo_hit;
  logic [31:0]      word;
  logic             word_valid;
  logic [ADDR_W:0]  wl_inc;

  assign receiving = (state == ST_LEN) || (state == ST_DATA);
  assign rearm     = start && !receiving;
  assign byte_acc  = receiving && rx_valid && !rx_ferr;
  assign tmo_hit   = (TIMEOUT_CYC != 0) && tmo_armed && (tmo_cnt == TMO_LAST);
  assign wl_inc    = words_loaded + (ADDR_W+1)'(1);

  uart_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (rearm),
    .byte_valid (byte_acc),
    .byte_data  (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      len_reg      <= '0;
      tmo_cnt      <= '0;
      tmo_armed    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_LEN;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            tmo_cnt      <= '0;
            tmo_armed    <= 1'b0;
          end
        end
        ST_LEN, ST_DATA: begin
          if (rx_ferr) begin
            state    <= ST_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_FRAME;
          end else if (byte_acc) begin
            tmo_cnt   <= '0;
            tmo_armed <= 1'b1;
            if (word_valid && state == ST_LEN) begin
              // Full 32-bit compare so huge counts cannot alias into range.
              if (word == 32'd0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (word > MAX_N) begin
                state    <= ST_ERR;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= ERR_LEN;
              end else begin
                state   <= ST_DATA;
                len_reg <= word[ADDR_W:0];
              end
            end else if (word_valid) begin
              mem_we       <= 1'b1;
              mem_addr     <= words_loaded[ADDR_W-1:0];
              mem_wdata    <= word;
              words_loaded <= wl_inc;
              if (wl_inc == len_reg) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end else if (tmo_hit) begin
            state    <= ST_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else if (tmo_armed) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
